uart_word_tx: RTL

Transmit-side framer for the UART link; it is the host-bound counterpart of the receive path. It accepts a parallel word from the datapath, such as an NN result, and emits it as a framed byte stream by driving the `uart` module's `start_transmit`/`data_to_send` inputs. It paces each byte on the UART's `tx_busy`. It sits between result logic and the `uart` instance and replaces the loopback wiring of the echo top.

---
 rtl/uart_word_tx_if.sv | 21 ++
 rtl/uart_word_tx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if: word handshake into the uart_word_tx framer.
// The producer drives word_in/word_valid; the framer returns word_ready.
interface uart_word_tx_if #(
  parameter int unsigned WORD_BYTES = 4
);
  logic [8*WORD_BYTES-1:0] word_in;
  logic                    word_valid;
  logic                    word_ready;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends HEADER then a word MSB-first as bytes to a uart.
// Define UART_WORD_TX_CHECKSUM_EN to append an XOR-of-payload byte.
module uart_word_tx #(
  parameter int unsigned WORD_BYTES  = 4,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_word_tx_if.slave word_if,
  input  logic          tx_busy,
  output logic          start_transmit,
  output logic [7:0]    data_to_send,
  output logic          busy,
  output logic          err
);
  localparam int unsigned W  = 8 * WORD_BYTES;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(ACK_TIMEOUT);
`ifdef UART_WORD_TX_CHECKSUM_EN
  localparam logic [3:0] PAY_LAST = 4'(WORD_BYTES);
  localparam logic [3:0] LAST     = 4'(WORD_BYTES + 1);
`else
  localparam logic [3:0] LAST     = 4'(WORD_BYTES);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
    NEXT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [7:0]    data_q, data_d;
  logic          start_q, start_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`ifdef UART_WORD_TX_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  assign start_transmit     = start_q;
  assign data_to_send       = data_q;
  assign err                = err_q;
  assign busy               = (state_q != IDLE);
  assign word_if.word_ready = (state_q == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sreg_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
`ifdef UART_WORD_TX_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`ifdef UART_WORD_TX_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    data_d  = data_q;
    start_d = 1'b0;
    tmo_d   = tmo_q;
    err_d   = err_q;
`ifdef UART_WORD_TX_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (word_if.word_valid) begin
          sreg_d  = word_if.word_in;
          idx_d   = '0;
          data_d  = HEADER;
          start_d = 1'b1;
          state_d = SEND;
`ifdef UART_WORD_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      SEND: begin
        tmo_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        // err flags as the count hits the limit; leave one cycle later
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (tmo_q == TMO) begin
          state_d = NEXT;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TMO) err_d = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == LAST) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          start_d = 1'b1;
          state_d = SEND;
`ifdef UART_WORD_TX_CHECKSUM_EN
          if (idx_q == PAY_LAST) begin
            data_d = csum_q;
          end else begin
            data_d = sreg_q[W-1 -: 8];
            sreg_d = sreg_q << 8;
            csum_d = csum_q ^ sreg_q[W-1 -: 8];
          end
`else
          data_d = sreg_q[W-1 -: 8];
          sreg_d = sreg_q << 8;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
